// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative vectoring-mode CORDIC computing atan2(y, x) and the
// uncompensated vector magnitude K*sqrt(x^2 + y^2), one micro-rotation per
// enabled clock and a single operation in flight.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   clk_en     advance enable; when low everything holds and no handshake completes
//   in_valid   operand valid          in_ready   high only while idle
//   x_in,y_in  signed Q2.WIDTH operands
//   out_valid  result valid (DONE)    out_ready  consumer takes the result
//   angle      signed Q3.WIDTH radians, range (-pi, +pi]
//   magnitude  unsigned Q4.WIDTH, K*r with K ~= 1.646760 left in
//
// The arctangent table is built at elaboration from 60-fractional-bit values,
// so WIDTH must stay at or below 56.
module cordic_atan2 #(
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [WIDTH+1:0] x_in,
  input  logic signed [WIDTH+1:0] y_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [WIDTH+2:0] angle,
  output logic        [WIDTH+3:0] magnitude
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // pi/4 and pi/2 scaled by 2^60
  localparam logic [63:0] PI4_60 = 64'h0C90_FDAA_2216_8C23;
  localparam logic [63:0] PI2_60 = 64'h1921_FB54_442D_1847;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // atan(2^-n) * 2^60. n = 0 uses the pi/4 constant; otherwise the Taylor
  // series, which converges by at least 4x per term for n >= 1.
  function automatic logic [63:0] atan60(input int n);
    logic [63:0] acc;
    logic [63:0] term;
    int          sh;
    acc = '0;
    if (n == 0) begin
      acc = PI4_60;
    end else begin
      for (int k = 0; k < 30; k++) begin
        sh = 60 - n * (2 * k + 1);
        if (sh >= 0) begin
          term = (64'd1 << sh) / 64'(2 * k + 1);
          if (k % 2 == 1) acc = acc - term;
          else            acc = acc + term;
        end
      end
    end
    return acc;
  endfunction

  // Round a 60-fractional-bit constant to WIDTH fractional bits.
  function automatic logic signed [WIDTH+2:0] rnd_frac(input logic [63:0] v);
    return (WIDTH+3)'((v + (64'd1 << (59 - WIDTH))) >> (60 - WIDTH));
  endfunction

  localparam logic signed [WIDTH+2:0] HALF_PI = rnd_frac(PI2_60);
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(WIDTH - 1);

  logic signed [WIDTH+2:0] atan_tab [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_atan
    localparam logic signed [WIDTH+2:0] ATAN_I = rnd_frac(atan60(g));
    assign atan_tab[g] = ATAN_I;
  end

  logic [1:0]              state;
  logic [CNT_W-1:0]        i;
  logic signed [WIDTH+3:0] xr;
  logic signed [WIDTH+3:0] yr;
  logic signed [WIDTH+2:0] zr;
  logic                    zero_flag;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Quadrant pre-rotation: fold the left half-plane into x >= 0 by +-90 deg.
  logic signed [WIDTH+3:0] x_ext;
  logic signed [WIDTH+3:0] y_ext;
  logic signed [WIDTH+3:0] x_ld;
  logic signed [WIDTH+3:0] y_ld;
  logic signed [WIDTH+2:0] z_ld;

  assign x_ext = {{2{x_in[WIDTH+1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH+1]}}, y_in};

  always_comb begin
    x_ld = x_ext;
    y_ld = y_ext;
    z_ld = '0;
    if (x_in[WIDTH+1]) begin
      if (!y_in[WIDTH+1]) begin
        x_ld = y_ext;
        y_ld = -x_ext;
        z_ld = HALF_PI;
      end else begin
        x_ld = -y_ext;
        y_ld = x_ext;
        z_ld = -HALF_PI;
      end
    end
  end

  // One micro-rotation driving yr toward zero; y == 0 counts as non-negative,
  // which keeps the x<0, y=0 case on the +pi side.
  logic signed [WIDTH+3:0] x_sh;
  logic signed [WIDTH+3:0] y_sh;
  logic signed [WIDTH+3:0] x_nx;
  logic signed [WIDTH+3:0] y_nx;
  logic signed [WIDTH+2:0] z_nx;

  assign x_sh = xr >>> i;
  assign y_sh = yr >>> i;

  always_comb begin
    if (!yr[WIDTH+3]) begin
      x_nx = xr + y_sh;
      y_nx = yr - x_sh;
      z_nx = zr + atan_tab[i];
    end else begin
      x_nx = xr - y_sh;
      y_nx = yr + x_sh;
      z_nx = zr - atan_tab[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      i         <= '0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      zero_flag <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            xr        <= x_ld;
            yr        <= y_ld;
            zr        <= z_ld;
            i         <= '0;
            // A zero vector has no direction; the iterations still run for
            // fixed latency but the result is forced to zero.
            zero_flag <= (x_in == '0) && (y_in == '0);
            state     <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          xr <= x_nx;
          yr <= y_nx;
          zr <= z_nx;
          i  <= i + CNT_W'(1);
          if (i == LAST) begin
            angle     <= zero_flag ? '0 : z_nx;
            magnitude <= zero_flag ? '0 : x_nx;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2.sv
// Directed bench for cordic_atan2 at WIDTH=24: a vector table of operands with
// hand-computed angles and radii, plus sequences for zero input, near -pi,
// backpressure, clk_en toggling, busy in_valid and reset abort.
module tb_cordic_atan2;

  localparam int     W     = 24;
  localparam longint TOL   = W + 2;
  localparam real    SCALE = 16777216.0;
  localparam int     NVEC  = 8;

  localparam logic signed [W+1:0] ONE  = 26'sh1000000;
  localparam logic signed [W+1:0] HALF = 26'sh0800000;
  localparam logic signed [W+1:0] ONE5 = 26'sh1800000;

  logic                clk = 1'b0;
  logic                reset;
  logic                clk_en;
  logic                in_valid;
  logic                in_ready;
  logic signed [W+1:0] x_in;
  logic signed [W+1:0] y_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W+2:0] angle;
  logic        [W+3:0] magnitude;

  cordic_atan2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .magnitude (magnitude)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W+1:0] x;
    logic signed [W+1:0] y;
    longint              ang;
    real                 r;
  } vec_t;

  vec_t   vecs [NVEC];
  int     n_checks = 0;
  int     n_pass   = 0;
  real    k_gain;
  real    p;
  int     lat;
  int     c;
  longint a;
  longint m;
  longint base_a;
  longint base_m;
  logic   seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp_v, input longint tol);
    n_checks++;
    if ((act - exp_v) <= tol && (exp_v - act) <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", name, act, exp_v, tol);
  endtask

  function automatic longint exp_mag(input real r);
    return longint'($rtoi(k_gain * r * SCALE + 0.5));
  endfunction

  // Accept one operand pair, count enabled edges until out_valid, capture the
  // result and release it.
  task automatic run_op(input logic signed [W+1:0] x, input logic signed [W+1:0] y,
                        output int lat_o, output longint a_o, output longint m_o);
    x_in      = x;
    y_in      = y;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat_o = 0;
    while (!out_valid && lat_o < 100) begin
      tick();
      lat_o++;
    end
    a_o = longint'(angle);
    m_o = longint'(magnitude);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;

    k_gain = 1.0;
    p      = 1.0;
    for (int j = 0; j < W; j++) begin
      k_gain = k_gain * $sqrt(1.0 + p);
      p      = p / 4.0;
    end

    vecs[0] = '{x: HALF,  y: HALF,  ang: 13176795,  r: 0.7071067811865476};
    vecs[1] = '{x: '0,    y: ONE,   ang: 26353589,  r: 1.0};
    vecs[2] = '{x: -ONE,  y: '0,    ang: 52707179,  r: 1.0};
    vecs[3] = '{x: ONE,   y: '0,    ang: 0,         r: 1.0};
    vecs[4] = '{x: HALF,  y: -HALF, ang: -13176795, r: 0.7071067811865476};
    vecs[5] = '{x: -HALF, y: HALF,  ang: 39530384,  r: 0.7071067811865476};
    vecs[6] = '{x: ONE,   y: HALF,  ang: 7778716,   r: 1.118033988749895};
    vecs[7] = '{x: -ONE5, y: -ONE,  ang: -42842132, r: 1.8027756377319946};

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready",  in_ready,  1, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_angle",     angle,     0, 0);
    chk("rst_magnitude", magnitude, 0, 0);
    reset = 1'b1;
    tick();

    // Vector table
    for (int v = 0; v < NVEC; v++) begin
      run_op(vecs[v].x, vecs[v].y, lat, a, m);
      chk($sformatf("vec%0d_latency", v), lat, 24, 0);
      chk($sformatf("vec%0d_angle", v), a, vecs[v].ang, TOL);
      chk($sformatf("vec%0d_magnitude", v), m, exp_mag(vecs[v].r), TOL);
      if (v == 0) begin
        base_a = a;
        base_m = m;
      end
    end

    // Zero vector: fixed latency, forced zero result
    run_op('0, '0, lat, a, m);
    chk("zero_latency",   lat, 24, 0);
    chk("zero_angle",     a,   0,  0);
    chk("zero_magnitude", m,   0,  0);

    // x<0 with y one LSB below zero lands just above -pi
    run_op(-ONE, 26'sd0 - 26'sd1, lat, a, m);
    chk("nearpi_negative", (a < 0), 1, 0);
    chk("nearpi_angle",    a, -52707178, TOL);

    // Backpressure
    x_in     = '0;
    y_in     = ONE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    chk("bp_latency", c, 24, 0);
    a = longint'(angle);
    m = longint'(magnitude);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("bp_hold%0d", j),
          (out_valid && !in_ready && longint'(angle) == a && longint'(magnitude) == m), 1, 0);
    end
    out_ready = 1'b1;
    clk_en    = 1'b0;
    tick();
    chk("bp_clken_blocks_handshake", out_valid, 1, 0);
    clk_en = 1'b1;
    tick();
    chk("bp_release_in_ready",  in_ready,  1, 0);
    chk("bp_release_out_valid", out_valid, 0, 0);
    out_ready = 1'b0;
    x_in      = HALF;
    y_in      = HALF;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_next_accept", in_ready, 0, 0);
    c = 0;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    chk("bp_next_latency",   c,                     24,     0);
    chk("bp_next_angle",     longint'(angle),       base_a, 0);
    chk("bp_next_magnitude", longint'(magnitude),   base_m, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // clk_en toggling, with in_valid held high on other operands while busy
    x_in     = HALF;
    y_in     = HALF;
    in_valid = 1'b1;
    tick();
    x_in = -ONE;
    y_in = '0;
    c = 0;
    while (!out_valid && c < 200) begin
      clk_en = (c % 2 == 1);
      tick();
      c++;
    end
    clk_en   = 1'b1;
    in_valid = 1'b0;
    chk("toggle_clocks",    c,                   48,     0);
    chk("toggle_angle",     longint'(angle),     base_a, 0);
    chk("toggle_magnitude", longint'(magnitude), base_m, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset abort at iteration 10, applied with clk_en low
    x_in     = ONE;
    y_in     = HALF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("abort_busy", in_ready, 0, 0);
    reset  = 1'b0;
    clk_en = 1'b0;
    tick();
    chk("abort_angle",     angle,     0, 0);
    chk("abort_magnitude", magnitude, 0, 0);
    chk("abort_in_ready",  in_ready,  1, 0);
    chk("abort_out_valid", out_valid, 0, 0);
    reset  = 1'b1;
    clk_en = 1'b1;
    seen   = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0, 0);
    run_op(-ONE5, -ONE, lat, a, m);
    chk("after_abort_latency",   lat, 24,                         0);
    chk("after_abort_angle",     a,   -42842132,                  TOL);
    chk("after_abort_magnitude", m,   exp_mag(1.8027756377319946), TOL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
